regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_scheduler_pkg.sv | 24 ++
 rtl/regfile_wb_scheduler_arbiter.sv | 47 ++++
 rtl/regfile_wb_scheduler.sv | 140 ++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mips_pkg
// Description : Shared sizing constants, register-address type and the
//               writeback requester-id encoding for the regfile writeback
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Requester ids double as bit positions in the arbiter valid/grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_scheduler_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Two-way round-robin arbiter for the writeback requesters.
//               A sole valid requester is granted; with both valid, the one
//               not granted most recently wins. Grant is a handshake because
//               it is only ever given to a valid requester.
// Ports       : clk, rst_n     - clock, asynchronous active-low reset
//               valid[1:0]     - request vector (bit REQ_ALU, bit REQ_MEM)
//               grant[1:0]     - one-hot grant, zero while in reset
// Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  import mips_pkg::*;

  req_id_t last_grant;

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant == REQ_ALU) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Reset value REQ_ALU makes MEM the favoured requester on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_ALU;
    end else if (grant[1]) begin
      last_grant <= REQ_MEM;
    end else if (grant[0]) begin
      last_grant <= REQ_ALU;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_scheduler
// Description : Busy scoreboard plus writeback scheduler for a register file.
//               Issue reserves a destination register, two writeback sources
//               (ALU, MEM) are arbitrated round-robin, and the winner is
//               written to the register file one cycle after its handshake,
//               retiring the reservation at the end of that write cycle.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               iss_valid/iss_rd/iss_ready      - issue-time reservation
//               alu_valid/addr/data/ready       - ALU writeback requester
//               mem_valid/addr/data/ready       - load writeback requester
//               rf_we/rf_waddr/rf_wdata         - register-file write port
//               q_addr1/2, q_busy1/2            - read-hazard queries
//               q_fwd1/2, q_fdata1/2            - bypass (REGFILE_WB_BYPASS_EN)
//               wb_err                          - sticky unreserved-write flag
// Config      : define REGFILE_WB_BYPASS_EN to add write-cycle forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int NUM_REGS = mips_pkg::NUM_REGS,
  parameter int DATA_W   = mips_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  input  mips_pkg::reg_addr_t iss_rd,
  output logic                iss_ready,
  input  logic                alu_valid,
  input  mips_pkg::reg_addr_t alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  mips_pkg::reg_addr_t mem_addr,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  output logic                rf_we,
  output mips_pkg::reg_addr_t rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  input  mips_pkg::reg_addr_t q_addr1,
  input  mips_pkg::reg_addr_t q_addr2,
  output logic                q_busy1,
  output logic                q_busy2,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                q_fwd1,
  output logic                q_fwd2,
  output logic [DATA_W-1:0]   q_fdata1,
  output logic [DATA_W-1:0]   q_fdata2,
`endif
  output logic                wb_err
);
  import mips_pkg::*;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic [1:0]          grant;
  logic                wb_fire;
  reg_addr_t           wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                iss_hit, wb_hit, q_hit1, q_hit2;
  logic                iss_set;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid ({mem_valid, alu_valid}),
    .grant (grant)
  );

  assign alu_ready = grant[0];
  assign mem_ready = grant[1];
  assign wb_fire   = |grant;
  assign wb_addr   = grant[1] ? mem_addr : alu_addr;
  assign wb_data   = grant[1] ? mem_data : alu_data;

  // Scoreboard lookups. Register 0 and addresses beyond NUM_REGS never
  // match, so they always read as not busy.
  always_comb begin
    iss_hit = 1'b0;
    wb_hit  = 1'b0;
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (32'(iss_rd)  == i) iss_hit = busy[i];
      if (32'(wb_addr) == i) wb_hit  = busy[i];
      if (32'(q_addr1) == i) q_hit1  = busy[i];
      if (32'(q_addr2) == i) q_hit2  = busy[i];
    end
  end

  // Ready looks at the current bit only, so a register retiring on this edge
  // still refuses a new reservation until the following cycle.
  assign iss_ready = rst_n & ~iss_hit;
  assign iss_set   = iss_valid & iss_ready & (iss_rd != '0);

  // Retire is applied before reserve: if both hit the same register, the new
  // reservation survives (the retiring write was to an unreserved register).
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rf_we   && 32'(rf_waddr) == i) busy_next[i] = 1'b0;
      if (iss_set && 32'(iss_rd)   == i) busy_next[i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy  <= busy_next;
      rf_we <= wb_fire && (wb_addr != '0);
      if (wb_fire && (wb_addr != '0)) begin
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
        if (!wb_hit) wb_err <= 1'b1;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // The write-cycle value is already final, so a reader may take it now and
  // need not stall on the still-set busy bit.
  assign q_fwd1   = rf_we && (rf_waddr == q_addr1) && (q_addr1 != '0);
  assign q_fwd2   = rf_we && (rf_waddr == q_addr2) && (q_addr2 != '0);
  assign q_fdata1 = rf_wdata;
  assign q_fdata2 = rf_wdata;
  assign q_busy1  = q_hit1 & ~q_fwd1;
  assign q_busy2  = q_hit2 & ~q_fwd2;
`else
  assign q_busy1  = q_hit1;
  assign q_busy2  = q_hit2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_scheduler
// Description : Self-checking bench for regfile_wb_scheduler: directed
//               scenarios followed by randomized traffic compared against a
//               behavioural scoreboard/arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, alu_valid, mem_valid;
  reg_addr_t   iss_rd, alu_addr, mem_addr, q_addr1, q_addr2, rf_waddr;
  logic [31:0] alu_data, mem_data, rf_wdata;
  logic        iss_ready, alu_ready, mem_ready, rf_we, q_busy1, q_busy2, wb_err;
`ifdef REGFILE_WB_BYPASS_EN
  logic        q_fwd1, q_fwd2;
  logic [31:0] q_fdata1, q_fdata2;
`endif

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
`ifdef REGFILE_WB_BYPASS_EN
    .q_fwd1(q_fwd1), .q_fwd2(q_fwd2), .q_fdata1(q_fdata1), .q_fdata2(q_fdata2),
`endif
    .wb_err(wb_err)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: set of reserved registers, who won last, pending write.
  bit          m_busy [32];
  bit          m_last_mem;
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;

  // Observations from the most recent cycle, for directed checks.
  logic obs_iss, obs_alu, obs_mem;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_mem = 1'b0;
    m_we       = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
    m_err      = 1'b0;
  endtask

  task automatic drive_idle();
    iss_valid = 0; iss_rd = '0;
    alu_valid = 0; alu_addr = '0; alu_data = '0;
    mem_valid = 0; mem_addr = '0; mem_data = '0;
    q_addr1 = '0; q_addr2 = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic exp_query(input logic [4:0] qa, input string tag,
                           input logic obs_b, input logic obs_f, input logic [31:0] obs_d);
    bit fwd;
    fwd = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    fwd = m_we && (m_waddr == qa) && (qa != 0);
    check({tag, "_fwd"}, obs_f, fwd);
    if (fwd) check({tag, "_fdata"}, obs_d, m_wdata);
`endif
    check({tag, "_busy"}, obs_b, fwd ? 1'b0 : m_busy[qa]);
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the
  // model on the edge, check registered outputs just after it.
  task automatic cycle(input bit iv, input logic [4:0] ird,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] qa1, input logic [4:0] qa2);
    bit ga, gm, ir;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic f1, f2;
    logic [31:0] d1, d2;
    iss_valid = iv; iss_rd = ird;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    q_addr1 = qa1; q_addr2 = qa2;
    #1;
    ir = !m_busy[ird];
    if (av && mv) begin
      gm = !m_last_mem; ga = m_last_mem;
    end else begin
      ga = av; gm = mv;
    end
    obs_iss = iss_ready; obs_alu = alu_ready; obs_mem = mem_ready;
    check("iss_ready", iss_ready, ir);
    check("alu_ready", alu_ready, ga);
    check("mem_ready", mem_ready, gm);
    f1 = 1'b0; f2 = 1'b0; d1 = '0; d2 = '0;
`ifdef REGFILE_WB_BYPASS_EN
    f1 = q_fwd1; f2 = q_fwd2; d1 = q_fdata1; d2 = q_fdata2;
`endif
    exp_query(qa1, "q1", q_busy1, f1, d1);
    exp_query(qa2, "q2", q_busy2, f2, d2);
    @(posedge clk);
    wa = gm ? ma : aa;
    wd = gm ? md : ad;
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (iv && ir && ird != 0) m_busy[ird] = 1'b1;
    m_we = 1'b0;
    if (ga || gm) begin
      m_last_mem = gm;
      if (wa != 0) begin
        // m_busy was already updated for this edge; the reservation check
        // must use the state seen at the handshake.
        m_we = 1'b1;
        m_waddr = wa;
        m_wdata = wd;
      end
    end
    #1;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    @(negedge clk);
  endtask

  // Error flag needs pre-edge reservation state, so it is tracked separately.
  task automatic cycle_e(input bit iv, input logic [4:0] ird,
                         input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] qa1, input logic [4:0] qa2);
    bit gm;
    logic [4:0] wa;
    bit reserved;
    gm = (av && mv) ? !m_last_mem : mv;
    wa = gm ? ma : aa;
    reserved = m_busy[wa];
    if ((av || mv) && wa != 0 && !reserved) m_err = 1'b1;
    cycle(iv, ird, av, aa, ad, mv, ma, md, qa1, qa2);
    check("wb_err", wb_err, m_err);
  endtask

  task automatic idle(input logic [4:0] qa1);
    cycle_e(0, 0, 0, 0, 0, 0, 0, 0, qa1, 0);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    iss_valid = 1; iss_rd = 5'd4; alu_valid = 1; mem_valid = 1;
    #12;
    check("rst_iss_ready", iss_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_wb_err", wb_err, 1'b0);
    @(negedge clk);
    do_reset();

    // Reserve 5, see it busy, write it back, see it retire.
    cycle_e(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    check("d1_q_busy_5", q_busy1, 1'b1);
    cycle_e(0, 0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
    check("d1_rf_we", rf_we, 1'b1);
    check("d1_waddr", rf_waddr, 5'd5);
    check("d1_wdata", rf_wdata, 32'h1234);
`ifdef REGFILE_WB_BYPASS_EN
    q_addr1 = 5'd5;
    #1;
    check("d6_fwd1", q_fwd1, 1'b1);
    check("d6_fdata1", q_fdata1, 32'h1234);
    check("d6_busy1", q_busy1, 1'b0);
`endif
    idle(5);
    idle(5);
    check("d1_retired", q_busy1, 1'b0);

    // Round-robin from reset: MEM, ALU, MEM, ALU.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle_e(0, 0, 1, 1, 32'(k), 1, 2, 32'(k + 16), 0, 0);
      check("d2_rr_mem", obs_mem, (k % 2) == 0);
      check("d2_rr_alu", obs_alu, (k % 2) == 1);
    end

    // Double reservation of 7 stalls until its writeback retires.
    do_reset();
    cycle_e(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle_e(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check("d3_stall_a", obs_iss, 1'b0);
    cycle_e(1, 7, 0, 0, 0, 1, 7, 32'h77, 7, 0);
    check("d3_stall_b", obs_iss, 1'b0);
    cycle_e(1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    check("d3_stall_retiring", obs_iss, 1'b0);
    cycle_e(1, 7, 0, 0, 0, 0, 0, 0, 7, 0);
    check("d3_accept", obs_iss, 1'b1);

    // Address 0 writeback is accepted silently; unreserved 9 raises wb_err.
    do_reset();
    cycle_e(0, 0, 0, 0, 0, 1, 0, 32'hAA, 0, 0);
    check("d4_zero_ready", obs_mem, 1'b1);
    check("d4_zero_no_we", rf_we, 1'b0);
    cycle_e(0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0);
    check("d4_unres_we", rf_we, 1'b1);
    check("d4_unres_err", wb_err, 1'b1);
    idle(0);
    idle(0);
    check("d4_err_sticky", wb_err, 1'b1);

    // Reset in the middle of a write cycle.
    do_reset();
    cycle_e(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle_e(0, 0, 1, 3, 32'h33, 0, 0, 0, 3, 0);
    check("d5_pre_we", rf_we, 1'b1);
    alu_valid = 1; iss_valid = 1; q_addr1 = 5'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check("d5_rst_we", rf_we, 1'b0);
    check("d5_rst_busy", q_busy1, 1'b0);
    check("d5_rst_alu_ready", alu_ready, 1'b0);
    check("d5_rst_iss_ready", iss_ready, 1'b0);
    @(negedge clk);
    drive_idle();
    model_reset();
    rst_n = 1'b1;
    idle(3);
    idle(3);
    check("d5_no_write", rf_we, 1'b0);

    // Randomized traffic on a small register window to force hazards.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cycle_e(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
